// File: rtl/refresh_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : refresh_scheduler_pkg
// Description : Shared types and defaults for the all-bank refresh scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package refresh_scheduler_pkg;

  typedef enum logic [1:0] {
    REF_IDLE  = 2'd0,
    REF_DRAIN = 2'd1,
    REF_REQ   = 2'd2,
    REF_RFC   = 2'd3
  } ref_state_e;

  localparam int T_REFI_DEF = 3900;
  localparam int T_RFC_DEF  = 295;

  // Counter width for a 0..n-1 down/up counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_scheduler_refi_timer.sv
`default_nettype none
// ============================================================================
// Module      : refi_timer
// Description : Free-running tREFI interval counter with a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module refi_timer
  import refresh_scheduler_pkg::*;
#(
  parameter int T_REFI = T_REFI_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              c_CW   = cnt_width(T_REFI);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(T_REFI - 1);

  logic [c_CW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = en && (r_cnt == c_LAST);
  assign tick   = w_wrap;

  // Disabled timer parks at zero so a re-enable always starts a full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_scheduler
// Description : Tracks owed all-bank refreshes and gates new bursts around REF.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int T_REFI       = T_REFI_DEF,
  parameter int T_RFC        = T_RFC_DEF,
  parameter int MAX_POSTPONE = 8,
  parameter int URGENT_TH    = 7,
  parameter int PW           = $clog2(MAX_POSTPONE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_done,
  input  logic          bursts_idle,
  output logic          ref_req,
  input  logic          ref_gnt,
  output logic          block_new_bursts,
  output logic          refresh_busy,
  output logic [PW-1:0] pending_cnt,
  output logic          overflow_err
);

  localparam int              c_RW     = cnt_width(T_RFC);
  localparam logic [c_RW-1:0] c_RFC_LD = c_RW'(T_RFC - 1);
  localparam logic [PW-1:0]   c_MAX    = PW'(MAX_POSTPONE);
  localparam logic [PW-1:0]   c_URGENT = PW'(URGENT_TH);

  ref_state_e      r_state;
  ref_state_e      w_next;
  logic [PW-1:0]   r_pending;
  logic [c_RW-1:0] r_rfc_cnt;
  logic            r_overflow;
  logic            w_tick;
  logic            w_accept;

  refi_timer #(
    .T_REFI (T_REFI)
  ) u_refi_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (init_done),
    .tick (w_tick)
  );

  // A grant only counts while we are actually asking for the slot.
  assign w_accept = (r_state == REF_REQ) && ref_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (w_tick && !w_accept) begin
      if (r_pending == c_MAX) begin
        r_overflow <= 1'b1;
      end else begin
        r_pending <= r_pending + 1'b1;
      end
    end else if (w_accept && !w_tick && (r_pending != '0)) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rfc_cnt <= '0;
    end else if (w_accept) begin
      r_rfc_cnt <= c_RFC_LD;
    end else if ((r_state == REF_RFC) && (r_rfc_cnt != '0)) begin
      r_rfc_cnt <= r_rfc_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= REF_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      REF_IDLE: begin
        if (r_pending >= c_URGENT) begin
          w_next = REF_DRAIN;
        end else if ((r_pending != '0) && bursts_idle) begin
          w_next = REF_REQ;
        end
      end
      REF_DRAIN: if (bursts_idle) w_next = REF_REQ;
      REF_REQ:   if (ref_gnt) w_next = REF_RFC;
      REF_RFC:   if (r_rfc_cnt == '0) w_next = REF_IDLE;
      default:   w_next = REF_IDLE;
    endcase
  end

  always_comb begin
    ref_req          = 1'b0;
    block_new_bursts = 1'b0;
    refresh_busy     = 1'b0;
    case (r_state)
      REF_DRAIN: block_new_bursts = 1'b1;
      REF_REQ: begin
        ref_req          = 1'b1;
        block_new_bursts = 1'b1;
      end
      REF_RFC: begin
        refresh_busy     = 1'b1;
        block_new_bursts = 1'b1;
      end
      default: ;
    endcase
  end

  assign pending_cnt  = r_pending;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_refresh_scheduler
// Description : Directed self-checking bench for refresh_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_refresh_scheduler;

  localparam int c_PW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_done = 1'b0;
  logic            bursts_idle = 1'b0;
  logic            ref_gnt = 1'b0;
  logic            ref_req;
  logic            block_new_bursts;
  logic            refresh_busy;
  logic [c_PW-1:0] pending_cnt;
  logic            overflow_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  refresh_scheduler #(
    .T_REFI       (20),
    .T_RFC        (5),
    .MAX_POSTPONE (4),
    .URGENT_TH    (3),
    .PW           (c_PW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .init_done        (init_done),
    .bursts_idle      (bursts_idle),
    .ref_req          (ref_req),
    .ref_gnt          (ref_gnt),
    .block_new_bursts (block_new_bursts),
    .refresh_busy     (refresh_busy),
    .pending_cnt      (pending_cnt),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle k is the window just after the k-th rising edge since cycle 0.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go_to(input int c);
    adv(c - cyc);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".ref_req"},  int'(ref_req), 0);
    check({tag, ".block"},    int'(block_new_bursts), 0);
    check({tag, ".busy"},     int'(refresh_busy), 0);
    check({tag, ".pending"},  int'(pending_cnt), 0);
    check({tag, ".overflow"}, int'(overflow_err), 0);
  endtask

  task automatic do_reset(input logic idle);
    rst         = 1'b1;
    init_done   = 1'b0;
    ref_gnt     = 1'b0;
    bursts_idle = idle;
    @(posedge clk);
    #1;
    check_idle_outs("rst");
    rst       = 1'b0;
    init_done = 1'b1;
    cyc       = 0;
  endtask

  initial begin
    logic seen;

    // 1: opportunistic refresh with bursts idle
    do_reset(1'b1);
    go_to(19); check("t1.pend19", int'(pending_cnt), 0);
    go_to(20); check("t1.pend20", int'(pending_cnt), 1);
               check("t1.req20",  int'(ref_req), 0);
    go_to(21); check("t1.req21",  int'(ref_req), 1);
               check("t1.blk21",  int'(block_new_bursts), 1);
    go_to(23); ref_gnt = 1'b1;
    go_to(24); ref_gnt = 1'b0;
               check("t1.pend24", int'(pending_cnt), 0);
               check("t1.busy24", int'(refresh_busy), 1);
               check("t1.req24",  int'(ref_req), 0);
    go_to(28); check("t1.busy28", int'(refresh_busy), 1);
    go_to(29); check("t1.busy29", int'(refresh_busy), 0);
               check("t1.blk29",  int'(block_new_bursts), 0);
               check("t1.req29",  int'(ref_req), 0);

    // 2: urgent drain when bursts stay busy
    do_reset(1'b0);
    go_to(40); check("t2.pend40", int'(pending_cnt), 2);
               check("t2.blk40",  int'(block_new_bursts), 0);
    go_to(60); check("t2.pend60", int'(pending_cnt), 3);
               check("t2.blk60",  int'(block_new_bursts), 0);
    go_to(61); check("t2.blk61",  int'(block_new_bursts), 1);
               check("t2.req61",  int'(ref_req), 0);
               bursts_idle = 1'b1;
    go_to(62); check("t2.req62",  int'(ref_req), 1);

    // 3: saturation and sticky overflow
    do_reset(1'b0);
    go_to(80);  check("t3.pend80", int'(pending_cnt), 4);
                check("t3.ovf80",  int'(overflow_err), 0);
    go_to(99);  check("t3.ovf99",  int'(overflow_err), 0);
    go_to(100); check("t3.pend100", int'(pending_cnt), 4);
                check("t3.ovf100",  int'(overflow_err), 1);
                bursts_idle = 1'b1;
    go_to(101); check("t3.req101", int'(ref_req), 1);
                ref_gnt = 1'b1;
    go_to(102); ref_gnt = 1'b0;
                check("t3.pend102", int'(pending_cnt), 3);
                check("t3.busy102", int'(refresh_busy), 1);
                check("t3.ovf102",  int'(overflow_err), 1);

    // 4: grant coincident with tick; REQ holds when bursts go busy
    do_reset(1'b0);
    go_to(40); check("t4.pend40", int'(pending_cnt), 2);
               bursts_idle = 1'b1;
    go_to(41); check("t4.req41", int'(ref_req), 1);
    go_to(45); bursts_idle = 1'b0;
    go_to(59); check("t4.req59", int'(ref_req), 1);
               ref_gnt = 1'b1;
    go_to(60); ref_gnt = 1'b0;
               check("t4.pend60", int'(pending_cnt), 2);
               check("t4.busy60", int'(refresh_busy), 1);
    go_to(65); check("t4.busy65", int'(refresh_busy), 0);

    // 5: asynchronous reset in the middle of tRFC
    do_reset(1'b1);
    go_to(21); check("t5.req21", int'(ref_req), 1);
    go_to(39); ref_gnt = 1'b1;
    go_to(40); ref_gnt = 1'b0;
               check("t5.pend40", int'(pending_cnt), 1);
               check("t5.busy40", int'(refresh_busy), 1);
    go_to(42); check("t5.busy42", int'(refresh_busy), 1);
               rst = 1'b1;
               #1;
               check_idle_outs("t5.midrst");
    @(posedge clk);
    #1;
    rst  = 1'b0;
    cyc  = 0;
    seen = ref_req;
    for (int i = 1; i <= 20; i++) begin
      adv(1);
      seen = seen | ref_req;
    end
    check("t5.noreq", int'(seen), 0);
    check("t5.pend20", int'(pending_cnt), 1);
    go_to(21); check("t5.req21b", int'(ref_req), 1);

    // 6: stray grant in IDLE, and timer restart after init_done drop
    do_reset(1'b0);
    go_to(20); check("t6.pend20", int'(pending_cnt), 1);
    go_to(25); ref_gnt = 1'b1;
    go_to(26); ref_gnt = 1'b0;
               check("t6.pend26", int'(pending_cnt), 1);
               check("t6.blk26",  int'(block_new_bursts), 0);
               check("t6.busy26", int'(refresh_busy), 0);
    go_to(30); init_done = 1'b0;
    go_to(40); check("t6.pend40", int'(pending_cnt), 1);
               init_done = 1'b1;
    go_to(59); check("t6.pend59", int'(pending_cnt), 1);
    go_to(60); check("t6.pend60", int'(pending_cnt), 2);
               check("t6.blk60",  int'(block_new_bursts), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
